// File: rtl/bitfusion_pkg.sv
// Shared types and constants for the bit-fusion PE feeder and its lane mapper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bitfusion_pkg;

    // Precision modes; the encoding 2'b11 is handled as 8-bit by consumers.
    localparam logic [1:0] MODE_2B = 2'b00;
    localparam logic [1:0] MODE_4B = 2'b01;
    localparam logic [1:0] MODE_8B = 2'b10;

    localparam int SUM_W        = 20;
    localparam int NUM_BRICKS   = 16;
    localparam int SHIFT_CODE_W = 3;
    localparam int OPND_W       = 2 * NUM_BRICKS;
    localparam int SIGN_W       = 4;
    localparam int SIGNAL_W     = NUM_BRICKS * SHIFT_CODE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] mode;
        logic       signed_a;
        logic       signed_b;
    } cfg_t;

    // Bricks form a 4x4 grid: row selects the A digit, column the B digit.
    function automatic int brick_row(input int i);
        return i / 4;
    endfunction

    function automatic int brick_col(input int i);
        return i % 4;
    endfunction

    // In 4-bit mode each 2x2 quadrant of the grid computes one nibble product.
    function automatic int brick_prod4(input int i);
        return 2 * (brick_row(i) / 2) + (brick_col(i) / 2);
    endfunction

endpackage

// File: rtl/pe_feeder_if.sv
// Operand/result stream plus PE-side bus between the feeder and its neighbours.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready follow valid-ready semantics.
interface pe_feeder_if;

    logic [1:0]                          cfg_mode;
    logic                                cfg_signed_a;
    logic                                cfg_signed_b;

    logic                                in_valid;
    logic                                in_ready;
    logic [bitfusion_pkg::OPND_W-1:0]    in_a;
    logic [bitfusion_pkg::OPND_W-1:0]    in_b;
    logic                                in_last;

    logic                                out_valid;
    logic                                out_ready;
    logic [bitfusion_pkg::SUM_W-1:0]     out_sum;

    logic [bitfusion_pkg::OPND_W-1:0]    pe_x;
    logic [bitfusion_pkg::OPND_W-1:0]    pe_y;
    logic [bitfusion_pkg::SIGN_W-1:0]    pe_sign_x;
    logic [bitfusion_pkg::SIGN_W-1:0]    pe_sign_y;
    logic [bitfusion_pkg::SIGNAL_W-1:0]  pe_signal;
    logic [bitfusion_pkg::SUM_W-1:0]     pe_previous_sum;
    logic [bitfusion_pkg::SUM_W-1:0]     pe_sum;

    // Feeder side.
    modport slave (
        input  cfg_mode, cfg_signed_a, cfg_signed_b,
        input  in_valid, in_a, in_b, in_last,
        output in_ready,
        output out_valid, out_sum,
        input  out_ready,
        output pe_x, pe_y, pe_sign_x, pe_sign_y, pe_signal, pe_previous_sum,
        input  pe_sum
    );

    // Operand source, result sink and PE array side.
    modport master (
        output cfg_mode, cfg_signed_a, cfg_signed_b,
        output in_valid, in_a, in_b, in_last,
        input  in_ready,
        input  out_valid, out_sum,
        output out_ready,
        input  pe_x, pe_y, pe_sign_x, pe_sign_y, pe_signal, pe_previous_sum,
        output pe_sum
    );

endinterface

// File: rtl/pe_lane_mapper.sv
// Crossbar from packed operands to the 16 2-bit bricks, their sign flags and shift codes.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the mapped operands are issued.
module pe_lane_mapper
    import bitfusion_pkg::*;
(
    input  logic [1:0]          mode,
    input  logic                signed_a,
    input  logic                signed_b,
    input  logic [OPND_W-1:0]   a,
    input  logic [OPND_W-1:0]   b,
    output logic [OPND_W-1:0]   x,
    output logic [OPND_W-1:0]   y,
    output logic [SIGN_W-1:0]   sign_x,
    output logic [SIGN_W-1:0]   sign_y,
    output logic [SIGNAL_W-1:0] signal
);

    // Route one 2-bit digit of A and of B into each brick and pick its shift code.
    always_comb begin
        x      = '0;
        y      = '0;
        signal = '0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            case (mode)
                MODE_2B: begin
                    // Sixteen independent 2-bit products, no shifting.
                    x[2*i +: 2] = a[2*i +: 2];
                    y[2*i +: 2] = b[2*i +: 2];
                    signal[SHIFT_CODE_W*i +: SHIFT_CODE_W] = '0;
                end
                MODE_4B: begin
                    // Each quadrant multiplies nibble k of A by nibble k of B.
                    x[2*i +: 2] = a[4*brick_prod4(i) + 2*(brick_row(i) % 2) +: 2];
                    y[2*i +: 2] = b[4*brick_prod4(i) + 2*(brick_col(i) % 2) +: 2];
                    signal[SHIFT_CODE_W*i +: SHIFT_CODE_W] =
                        SHIFT_CODE_W'((brick_row(i) % 2) + (brick_col(i) % 2));
                end
                default: begin
                    // One 8x8 product: digit r of A times digit c of B, weight 4^(r+c).
                    x[2*i +: 2] = a[2*brick_row(i) +: 2];
                    y[2*i +: 2] = b[2*brick_col(i) +: 2];
                    signal[SHIFT_CODE_W*i +: SHIFT_CODE_W] =
                        SHIFT_CODE_W'(brick_row(i) + brick_col(i));
                end
            endcase
        end
    end

    // Only the most significant digit of each operand carries the sign.
    always_comb begin
        sign_x = '0;
        sign_y = '0;
        case (mode)
            MODE_2B: begin
                sign_x = {SIGN_W{signed_a}};
                sign_y = {SIGN_W{signed_b}};
            end
            MODE_4B: begin
                sign_x = {signed_a, 1'b0, signed_a, 1'b0};
                sign_y = {signed_b, 1'b0, signed_b, 1'b0};
            end
            default: begin
                sign_x = {signed_a, 3'b000};
                sign_y = {signed_b, 3'b000};
            end
        endcase
    end

endmodule

// File: rtl/pe_feeder.sv
// Feeds packed operand beats into the PE array and accumulates the dot product.
// Latency: out_valid two cycles after the last beat is accepted.
// Backpressure: in_ready low while draining/holding; result held until out_ready.
module pe_feeder
    import bitfusion_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    pe_feeder_if.slave bus
);

    state_t              state_q;
    state_t              state_d;
    cfg_t                cfg_q;
    cfg_t                cfg_live;
    cfg_t                cfg_eff;
    logic                in_ready_int;
    logic                accept;
    logic                first_beat;
    logic                acc_ld_q;
    logic [SUM_W-1:0]    acc_q;
    logic [SUM_W-1:0]    out_sum_q;
    logic [OPND_W-1:0]   map_x;
    logic [OPND_W-1:0]   map_y;
    logic [SIGN_W-1:0]   map_sign_x;
    logic [SIGN_W-1:0]   map_sign_y;
    logic [SIGNAL_W-1:0] map_signal;

    assign cfg_live     = {bus.cfg_mode, bus.cfg_signed_a, bus.cfg_signed_b};
    assign first_beat   = (state_q == IDLE);
    // The first beat uses the live cfg; later beats reuse what was latched then.
    assign cfg_eff      = first_beat ? cfg_live : cfg_q;
    assign in_ready_int = (state_q == IDLE) || (state_q == ACCUM);
    assign accept       = bus.in_valid && in_ready_int;

    pe_lane_mapper u_mapper (
        .mode     (cfg_eff.mode),
        .signed_a (cfg_eff.signed_a),
        .signed_b (cfg_eff.signed_b),
        .a        (bus.in_a),
        .b        (bus.in_b),
        .x        (map_x),
        .y        (map_y),
        .sign_x   (map_sign_x),
        .sign_y   (map_sign_y),
        .signal   (map_signal)
    );

    // Operands reach the PE only in accept cycles so idle cycles add nothing.
    assign bus.pe_x            = accept ? map_x      : '0;
    assign bus.pe_y            = accept ? map_y      : '0;
    assign bus.pe_sign_x       = accept ? map_sign_x : '0;
    assign bus.pe_sign_y       = accept ? map_sign_y : '0;
    assign bus.pe_signal       = map_signal;
    assign bus.pe_previous_sum = acc_q;

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = out_sum_q;

    // Packet state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept beats until the last one, drain one cycle, hold until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d = bus.in_last ? DRAIN : ACCUM;
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the packet's cfg on its first accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else if (accept && first_beat) begin
            cfg_q <= cfg_live;
        end
    end

    // Fold the PE result into acc the cycle after each accept; DRAIN publishes and clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_ld_q  <= 1'b0;
            acc_q     <= '0;
            out_sum_q <= '0;
        end else begin
            acc_ld_q <= accept;
            if (state_q == DRAIN) begin
                out_sum_q <= bus.pe_sum;
                acc_q     <= '0;
            end else if (acc_ld_q) begin
                acc_q <= bus.pe_sum;
            end
        end
    end

endmodule
